// File: rtl/dp_ram_batch_controller.sv
// Batch controller: reads operand pairs from a dual-port RAM, drives an external multiplier
// and writes products back, then handshakes STATUS/CONTROL. Optional watchdog: DP_RAM_BATCH_TIMEOUT_EN.
module dp_ram_batch_controller #(
    parameter int OPW         = 4,
    parameter int NJOB        = 4,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                CLK,
    input  logic                rst,
    output logic [ADDR_W-1:0]   ADDR,
    output logic                WRITE_F,
    output logic [31:0]         WRITE_DATA,
    input  logic [31:0]         READ_DATA,
    output logic [3:0]          BYTE_ENABLE,
    output logic [OPW-1:0]      A,
    output logic [OPW-1:0]      B,
    output logic                ena,
    input  logic                done,
    input  logic [2*OPW-1:0]    Y,
    output logic [3:0]          state_o,
    output logic [5:0]          job_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_ADDR  = 4'd1,
        S_RD_LATCH = 4'd2,
        S_MUL      = 4'd3,
        S_WR_OUT   = 4'd4,
        S_NEXT     = 4'd5,
        S_SET_DONE = 4'd6,
        S_WAIT_CLR = 4'd7,
        S_CLEAR    = 4'd8
    } state_t;

    localparam logic [ADDR_W-1:0] CTRL_ADDR = '0;
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   prev_addr_q;
    logic                wr_q, wr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [OPW-1:0]      a_q, a_d, b_q, b_d;
    logic                ena_q, ena_d;
    logic [5:0]          job_q, job_d;
    logic                err_q, err_d;
    logic                rd_unused;

    function automatic logic [ADDR_W-1:0] din_addr(input logic [5:0] j);
        return ADDR_W'(32'(j) + 32'd2);
    endfunction

    function automatic logic [ADDR_W-1:0] dout_addr(input logic [5:0] j);
        return ADDR_W'(32'(j) + 32'(2 + NJOB));
    endfunction

`ifdef DP_RAM_BATCH_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
`else
    localparam int tmo_unused = TIMEOUT_CYC;
`endif

    assign rd_unused = ^READ_DATA;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        a_d     = a_q;
        b_d     = b_q;
        ena_d   = ena_q;
        job_d   = job_q;
        err_d   = err_q;
`ifdef DP_RAM_BATCH_TIMEOUT_EN
        tmo_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                addr_d = CTRL_ADDR;
                // READ_DATA only reflects CONTROL once the address has been presented a full cycle
                if (prev_addr_q == CTRL_ADDR && READ_DATA[0]) begin
                    job_d   = '0;
                    err_d   = 1'b0;
                    addr_d  = STAT_ADDR;
                    wr_d    = 1'b1;
                    wdata_d = 32'd2;
                    state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                addr_d = din_addr(job_q);
                if (!wr_q) state_d = S_RD_LATCH;
            end
            S_RD_LATCH: begin
                a_d     = READ_DATA[OPW-1:0];
                b_d     = READ_DATA[2*OPW-1:OPW];
                ena_d   = 1'b1;
                state_d = S_MUL;
            end
            S_MUL: begin
`ifdef DP_RAM_BATCH_TIMEOUT_EN
                tmo_d = tmo_q + 1'b1;
`endif
                if (done) begin
                    ena_d   = 1'b0;
                    addr_d  = dout_addr(job_q);
                    wr_d    = 1'b1;
                    wdata_d = 32'(Y);
                    state_d = S_WR_OUT;
                end
`ifdef DP_RAM_BATCH_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    ena_d   = 1'b0;
                    addr_d  = dout_addr(job_q);
                    wr_d    = 1'b1;
                    wdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_WR_OUT;
                end
`endif
            end
            S_WR_OUT: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (job_q == 6'(NJOB - 1)) begin
                    addr_d  = STAT_ADDR;
                    wr_d    = 1'b1;
                    wdata_d = {29'd0, err_q, 2'b01};
                    state_d = S_SET_DONE;
                end else begin
                    // Prefetch the next operand address so RD_ADDR costs a single cycle
                    job_d   = job_q + 6'd1;
                    addr_d  = din_addr(job_q + 6'd1);
                    state_d = S_RD_ADDR;
                end
            end
            S_SET_DONE: begin
                addr_d  = CTRL_ADDR;
                state_d = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                addr_d = CTRL_ADDR;
                if (prev_addr_q == CTRL_ADDR && !READ_DATA[0]) begin
                    addr_d  = STAT_ADDR;
                    wr_d    = 1'b1;
                    wdata_d = 32'd0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                addr_d  = CTRL_ADDR;
                state_d = S_IDLE;
            end
            default: begin
                addr_d  = CTRL_ADDR;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            prev_addr_q <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ena_q       <= 1'b0;
            job_q       <= '0;
            err_q       <= 1'b0;
`ifdef DP_RAM_BATCH_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            prev_addr_q <= addr_q;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ena_q       <= ena_d;
            job_q       <= job_d;
            err_q       <= err_d;
`ifdef DP_RAM_BATCH_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign ADDR        = addr_q;
    assign WRITE_F     = wr_q;
    assign WRITE_DATA  = wdata_q;
    assign BYTE_ENABLE = 4'hF;
    assign A           = a_q;
    assign B           = b_q;
    assign ena         = ena_q;
    assign state_o     = state_q;
    assign job_o       = job_q;

endmodule
